// File: rtl/vlg_sonar_sched_pkg.sv
// Shared types and helpers for the round-robin sonar scheduler.
// It holds the FSM encoding, the channel-index width, default timing and the channel picker.
package vlg_sonar_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_REPORT    = 3'd4,
    ST_GAP       = 3'd5
  } state_t;

  localparam int CH_IDX_W       = 3;
  localparam int MAX_CH         = 8;
  localparam int DEF_TRIG_US    = 10;
  localparam int DEF_TIMEOUT_US = 30000;
  localparam int DEF_GAP_US     = 60000;
  localparam int DEF_CNT_W      = 17;

  // First set mask bit at or after ptr, wrapping within num_ch; returns ptr if none set.
  function automatic logic [CH_IDX_W-1:0] pick_ch(input logic [MAX_CH-1:0]   mask,
                                                  input logic [CH_IDX_W-1:0] ptr,
                                                  input int                  num_ch);
    logic [CH_IDX_W-1:0] sel;
    int                  idx;
    sel = ptr;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= num_ch) idx = idx - num_ch;
      if (i < num_ch && mask[idx[CH_IDX_W-1:0]]) sel = idx[CH_IDX_W-1:0];
    end
    return sel;
  endfunction

endpackage

// File: rtl/vlg_sonar_sched_sync2.sv
// Two-flop synchronizer for the raw echo inputs, cleared by the synchronous reset.
module vlg_sync2 #(
  parameter int P_W = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [P_W-1:0] i_d,
  output logic [P_W-1:0] o_q
);

  logic [P_W-1:0] meta_q;
  logic [P_W-1:0] sync_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/vlg_sonar_sched.sv
// Round-robin ultrasonic ranging scheduler: one trigger at a time, echo width in ticks, valid/ready result.
// Result handshake: o_res_valid rises with stable data and holds it until a clock where i_res_ready is also high.
module vlg_sonar_sched
  import vlg_sonar_sched_pkg::*;
#(
  parameter int P_NUM_CH     = 4,
  parameter int P_TRIG_US    = DEF_TRIG_US,
  parameter int P_TIMEOUT_US = DEF_TIMEOUT_US,
  parameter int P_GAP_US     = DEF_GAP_US,
  parameter int P_CNT_W      = DEF_CNT_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clk_en,
  input  logic                i_enable,
  input  logic [P_NUM_CH-1:0] i_ch_mask,
  input  logic [P_NUM_CH-1:0] i_echo,
  output logic [P_NUM_CH-1:0] o_trig,
  output logic                o_res_valid,
  input  logic                i_res_ready,
  output logic [2:0]          o_res_ch,
  output logic [P_CNT_W-1:0]  o_echo_us,
  output logic                o_res_tmo,
  output logic                o_busy,
  output state_t              o_dbg_state
);

  localparam logic [P_CNT_W-1:0]  TRIG_LAST = P_CNT_W'(P_TRIG_US - 1);
  localparam logic [P_CNT_W-1:0]  TO_LAST   = P_CNT_W'(P_TIMEOUT_US - 1);
  localparam logic [P_CNT_W-1:0]  TO_VAL    = P_CNT_W'(P_TIMEOUT_US);
  localparam logic [P_CNT_W-1:0]  GAP_LAST  = P_CNT_W'(P_GAP_US - 1);
  localparam logic [CH_IDX_W-1:0] LAST_CH   = CH_IDX_W'(P_NUM_CH - 1);

  state_t                state_q, state_d;
  logic [CH_IDX_W-1:0]   ptr_q, ptr_d, ch_q, ch_d, res_ch_q, res_ch_d, sel;
  logic [P_CNT_W-1:0]    tick_q, tick_d, width_q, width_d, echo_us_q, echo_us_d;
  logic [P_NUM_CH-1:0]   trig_q, trig_d, echo_s, echo_d_q;
  logic                  valid_q, valid_d, tmo_q, tmo_d;
  logic [MAX_CH-1:0]     echo_s8, echo_d8, mask8, sel_onehot;
  logic                  rise, fall, can_start;

  vlg_sync2 #(.P_W(P_NUM_CH)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_echo),
    .o_q   (echo_s)
  );

  // Widen to 8 lanes so the 3-bit channel index selects without width games.
  assign echo_s8    = MAX_CH'(echo_s);
  assign echo_d8    = MAX_CH'(echo_d_q);
  assign mask8      = MAX_CH'(i_ch_mask);
  assign rise       = echo_s8[ch_q] & ~echo_d8[ch_q];
  assign fall       = ~echo_s8[ch_q] & echo_d8[ch_q];
  assign can_start  = i_enable & (|i_ch_mask);
  assign sel        = pick_ch(mask8, ptr_q, P_NUM_CH);
  assign sel_onehot = MAX_CH'(1) << sel;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ch_d      = ch_q;
    tick_d    = tick_q;
    width_d   = width_q;
    trig_d    = trig_q;
    valid_d   = valid_q;
    res_ch_d  = res_ch_q;
    echo_us_d = echo_us_q;
    tmo_d     = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (i_clk_en && can_start) begin
          ch_d    = sel;
          trig_d  = sel_onehot[P_NUM_CH-1:0];
          tick_d  = '0;
          state_d = ST_TRIG;
        end
      end
      ST_TRIG: begin
        if (i_clk_en) begin
          if (tick_q == TRIG_LAST) begin
            trig_d  = '0;
            tick_d  = '0;
            state_d = ST_WAIT_RISE;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      ST_WAIT_RISE: begin
        // Only a fresh rise counts; an echo already high on entry runs into the timeout.
        if (rise) begin
          width_d = '0;
          state_d = ST_MEASURE;
        end else if (i_clk_en) begin
          if (tick_q == TO_LAST) begin
            valid_d   = 1'b1;
            res_ch_d  = ch_q;
            echo_us_d = '0;
            tmo_d     = 1'b1;
            state_d   = ST_REPORT;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      ST_MEASURE: begin
        if (fall) begin
          valid_d   = 1'b1;
          res_ch_d  = ch_q;
          echo_us_d = width_q;
          tmo_d     = 1'b0;
          state_d   = ST_REPORT;
        end else if (i_clk_en && echo_s8[ch_q]) begin
          if (width_q == TO_LAST) begin
            valid_d   = 1'b1;
            res_ch_d  = ch_q;
            echo_us_d = TO_VAL;
            tmo_d     = 1'b1;
            state_d   = ST_REPORT;
          end else begin
            width_d = width_q + 1'b1;
          end
        end
      end
      ST_REPORT: begin
        if (i_res_ready) begin
          valid_d = 1'b0;
          ptr_d   = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
          tick_d  = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (i_clk_en) begin
          if (tick_q == GAP_LAST) begin
            tick_d = '0;
            if (can_start) begin
              ch_d    = sel;
              trig_d  = sel_onehot[P_NUM_CH-1:0];
              state_d = ST_TRIG;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      ch_q      <= '0;
      tick_q    <= '0;
      width_q   <= '0;
      trig_q    <= '0;
      valid_q   <= 1'b0;
      res_ch_q  <= '0;
      echo_us_q <= '0;
      tmo_q     <= 1'b0;
      echo_d_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ch_q      <= ch_d;
      tick_q    <= tick_d;
      width_q   <= width_d;
      trig_q    <= trig_d;
      valid_q   <= valid_d;
      res_ch_q  <= res_ch_d;
      echo_us_q <= echo_us_d;
      tmo_q     <= tmo_d;
      echo_d_q  <= echo_s;
    end
  end

  assign o_trig      = trig_q;
  assign o_res_valid = valid_q;
  assign o_res_ch    = res_ch_q;
  assign o_echo_us   = echo_us_q;
  assign o_res_tmo   = tmo_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_vlg_sonar_sched.sv
// Bench for vlg_sonar_sched: directed shot table, multi-cycle corner sequences, then randomized shots
// whose expected channel and result come from a round-robin/measurement model.
module tb_vlg_sonar_sched;
  import vlg_sonar_sched_pkg::*;

  localparam int NCH    = 4;
  localparam int TRIG   = 10;
  localparam int TO     = 700;
  localparam int GAP    = 100;
  localparam int CW     = 17;
  localparam int BUDGET = 20000;
  localparam int RW     = 1 + 3 + CW;

  typedef struct {
    logic [NCH-1:0] mask;
    int             d;
    int             w;
    bit             no_echo;
    bit             stuck;
    int             rdy;
    bit             drop_en;
    logic [NCH-1:0] mask_after;
    logic [2:0]     exp_ch;
    logic [CW-1:0]  exp_echo;
    bit             exp_tmo;
  } shot_t;

  logic           i_clk = 1'b0;
  logic           i_rst = 1'b1;
  logic           i_clk_en = 1'b0;
  logic           i_enable = 1'b0;
  logic [NCH-1:0] i_ch_mask = '0;
  logic [NCH-1:0] i_echo = '0;
  logic           i_res_ready = 1'b0;
  logic [NCH-1:0] o_trig;
  logic           o_res_valid;
  logic [2:0]     o_res_ch;
  logic [CW-1:0]  o_echo_us;
  logic           o_res_tmo;
  logic           o_busy;
  state_t         dbg_state;

  int             checks = 0;
  int             failures = 0;
  bit             gap_chk = 1'b0;
  logic [RW-1:0]  exp_q[$];
  shot_t          tbl[10];

  vlg_sonar_sched #(
    .P_NUM_CH(NCH), .P_TRIG_US(TRIG), .P_TIMEOUT_US(TO), .P_GAP_US(GAP), .P_CNT_W(CW)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clk_en    (i_clk_en),
    .i_enable    (i_enable),
    .i_ch_mask   (i_ch_mask),
    .i_echo      (i_echo),
    .o_trig      (o_trig),
    .o_res_valid (o_res_valid),
    .i_res_ready (i_res_ready),
    .o_res_ch    (o_res_ch),
    .o_echo_us   (o_echo_us),
    .o_res_tmo   (o_res_tmo),
    .o_busy      (o_busy),
    .o_dbg_state (dbg_state)
  );

  // Clock and a 1-in-2 tick enable that changes just after each rising edge.
  always #5 i_clk = ~i_clk;
  initial begin
    forever begin
      @(posedge i_clk);
      #2 i_clk_en = ~i_clk_en;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog time_limit_reached actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Leaves the bench at the falling edge just after the next tick edge.
  task automatic after_tick();
    do @(negedge i_clk); while (!i_clk_en);
    @(negedge i_clk);
  endtask

  function automatic logic [2:0] model_pick(input logic [NCH-1:0] m, input int p);
    for (int i = 0; i < NCH; i++) begin
      if (m[(p + i) % NCH]) return 3'((p + i) % NCH);
    end
    return 3'(p);
  endfunction

  task automatic do_shot(input shot_t s);
    int             n, gt, tt, lat;
    logic [NCH-1:0] oh;
    logic [RW-1:0]  exp_r;
    logic [2:0]     rch;
    logic [CW-1:0]  rus;
    logic           rtmo;
    bit             stable;
    i_ch_mask = s.mask;
    exp_q.push_back({s.exp_tmo, s.exp_ch, s.exp_echo});
    if (s.stuck) i_echo[s.exp_ch[1:0]] = 1'b1;
    n = 0;
    gt = 0;
    while (o_trig == '0 && n < BUDGET) begin
      if (i_clk_en) gt++;
      n++;
      @(negedge i_clk);
    end
    check("trig_start", 32'(o_trig != '0), 1);
    if (o_trig == '0) begin
      void'(exp_q.pop_front());
      return;
    end
    oh = NCH'(1) << s.exp_ch;
    check("trig_onehot", 32'(o_trig), 32'(oh));
    if (gap_chk) check("gap_ticks", gt, GAP);
    i_ch_mask = s.mask_after;
    tt = 0;
    while (o_trig != '0 && n < BUDGET) begin
      if (i_clk_en) tt++;
      n++;
      @(negedge i_clk);
    end
    check("trig_ticks", tt, TRIG);
    if (s.no_echo || s.stuck) begin
      lat = 0;
      while (!o_res_valid && n < BUDGET) begin
        if (i_clk_en) lat++;
        n++;
        @(negedge i_clk);
      end
      check("tmo_latency", lat, TO);
    end else begin
      repeat (s.d) after_tick();
      i_echo[s.exp_ch[1:0]] = 1'b1;
      if (s.w == 0) begin
        @(negedge i_clk);
      end else begin
        for (int k = 0; k < s.w; k++) begin
          if (s.drop_en && k == 2) i_enable = 1'b0;
          after_tick();
        end
      end
      i_echo[s.exp_ch[1:0]] = 1'b0;
      while (!o_res_valid && n < BUDGET) begin
        n++;
        @(negedge i_clk);
      end
    end
    check("res_valid", 32'(o_res_valid), 1);
    exp_r = exp_q.pop_front();
    check("res_ch", 32'(o_res_ch), 32'(exp_r[RW-2 -: 3]));
    check("echo_us", 32'(o_echo_us), 32'(exp_r[CW-1:0]));
    check("res_tmo", 32'(o_res_tmo), 32'(exp_r[RW-1]));
    if (!o_res_valid) return;
    rch = o_res_ch;
    rus = o_echo_us;
    rtmo = o_res_tmo;
    stable = 1'b1;
    repeat (s.rdy) begin
      @(negedge i_clk);
      if (!(o_res_valid && o_res_ch == rch && o_echo_us == rus && o_res_tmo == rtmo && o_trig == '0))
        stable = 1'b0;
    end
    if (s.rdy > 0) check("stall_stable", 32'(stable), 1);
    i_res_ready = 1'b1;
    @(negedge i_clk);
    i_res_ready = 1'b0;
    check("valid_drop", 32'(o_res_valid), 0);
    if (s.stuck) i_echo[s.exp_ch[1:0]] = 1'b0;
    gap_chk = 1'b1;
  endtask

  initial begin
    int    n, model_ptr;
    bit    seen;
    shot_t s;
    //          mask     d    w     noe stk rdy drop after    ch    echo  tmo
    tbl[0] = '{4'b0101, 200, 580,  0,  0,  2,  0, 4'b0101, 3'd0, 17'd580, 1'b0};
    tbl[1] = '{4'b0101, 5,   3,    0,  0,  50, 0, 4'b0101, 3'd2, 17'd3,   1'b0};
    tbl[2] = '{4'b0010, 0,   0,    1,  0,  0,  0, 4'b0010, 3'd1, 17'd0,   1'b1};
    tbl[3] = '{4'b0010, 3,   1200, 0,  0,  0,  0, 4'b0010, 3'd1, 17'd700, 1'b1};
    tbl[4] = '{4'b0010, 1,   699,  0,  0,  1,  0, 4'b0010, 3'd1, 17'd699, 1'b0};
    tbl[5] = '{4'b1000, 2,   700,  0,  0,  0,  0, 4'b1000, 3'd3, 17'd700, 1'b1};
    tbl[6] = '{4'b1000, 4,   0,    0,  0,  3,  0, 4'b1000, 3'd3, 17'd0,   1'b0};
    tbl[7] = '{4'b0100, 0,   0,    0,  1,  0,  0, 4'b0100, 3'd2, 17'd0,   1'b1};
    tbl[8] = '{4'b1001, 0,   1,    0,  0,  0,  0, 4'b1001, 3'd3, 17'd1,   1'b0};
    tbl[9] = '{4'b1001, 7,   40,   0,  0,  0,  1, 4'b1001, 3'd0, 17'd40,  1'b0};

    repeat (4) @(negedge i_clk);
    check("rst_trig", 32'(o_trig), 0);
    check("rst_valid", 32'(o_res_valid), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_ch", 32'(o_res_ch), 0);
    check("rst_echo", 32'(o_echo_us), 0);
    check("rst_tmo", 32'(o_res_tmo), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    i_rst = 1'b0;
    i_ch_mask = 4'b1111;
    seen = 1'b0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_busy || o_trig != '0) seen = 1'b1;
    end
    check("idle_when_disabled", 32'(seen), 0);

    i_enable = 1'b1;
    gap_chk = 1'b0;
    for (int i = 0; i < 10; i++) do_shot(tbl[i]);

    // Enable was dropped mid-measurement: the shot finished, GAP ran out, no new trigger.
    gap_chk = 1'b0;
    seen = 1'b0;
    repeat (2 * (GAP + 20)) begin
      @(negedge i_clk);
      if (o_trig != '0) seen = 1'b1;
    end
    check("no_trig_after_disable", 32'(seen), 0);
    check("busy_after_disable", 32'(o_busy), 0);
    check("state_after_disable", 32'(dbg_state), 32'(ST_IDLE));

    // Reset in TRIG: pointer was at ch1, restart must pick ch0.
    i_ch_mask = 4'b1111;
    i_enable = 1'b1;
    n = 0;
    while (o_trig == '0 && n < BUDGET) begin
      n++;
      @(negedge i_clk);
    end
    check("pre_rst_trig", 32'(o_trig), 32'(4'b0010));
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("rst_mid_trig", 32'(o_trig), 0);
    check("rst_mid_valid", 32'(o_res_valid), 0);
    check("rst_mid_busy", 32'(o_busy), 0);
    i_rst = 1'b0;
    s = '{4'b1111, 3, 20, 0, 0, 0, 0, 4'b1111, 3'd0, 17'd20, 1'b0};
    do_shot(s);
    model_ptr = 1;

    for (int k = 0; k < 25; k++) begin
      int mode;
      s.mask = NCH'($urandom_range(1, 15));
      s.mask_after = NCH'($urandom_range(1, 15));
      s.d = $urandom_range(0, 60);
      s.rdy = $urandom_range(0, 6);
      s.stuck = 1'b0;
      s.drop_en = 1'b0;
      mode = $urandom_range(0, 7);
      s.no_echo = (mode == 0);
      s.w = (mode == 1) ? $urandom_range(TO - 1, TO + 1) : $urandom_range(0, 120);
      s.exp_ch = model_pick(s.mask, model_ptr);
      if (s.no_echo) begin
        s.exp_echo = '0;
        s.exp_tmo = 1'b1;
      end else if (s.w >= TO) begin
        s.exp_echo = CW'(TO);
        s.exp_tmo = 1'b1;
      end else begin
        s.exp_echo = CW'(s.w);
        s.exp_tmo = 1'b0;
      end
      do_shot(s);
      model_ptr = (int'(s.exp_ch) + 1) % NCH;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
